varredura_display: RTL and testbench

- Time-multiplexed scan controller for N_DIG seven-segment digits that share one BCD-to-7-segment decoder instance.
- Holds the displayed digit values and sequences the digit selects.
- Drives the shared decoder's 4-bit input and enable, with a blanking guard interval between digits to prevent ghosting.
- Sits between the application (which loads BCD values) and the decoder/anode drivers.

---
 rtl/varredura_display_pkg.sv | 15 +
 rtl/divisor_tick.sv | 29 ++
 rtl/varredura_display.sv | 141 ++++++++++++++
 tb/tb_varredura_display.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/varredura_display_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// FSM state encoding and default timing values.
package varredura_display_pkg;

    typedef enum logic {
        APAGA = 1'b0,
        EXIBE = 1'b1
    } estado_t;

    localparam int N_DIG_PADRAO = 4;
    localparam int DIV_PADRAO   = 50000;
    localparam int SLOT_PADRAO  = 16;
    localparam int BLANK_PADRAO = 2;

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: emits a one-cycle tick every DIV clock cycles, first tick in
// cycle DIV after reset release.
module divisor_tick
    import varredura_display_pkg::*;
#(
    parameter int DIV = DIV_PADRAO
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/varredura_display.sv
// Scan controller: holds N_DIG BCD digits, sequences one-hot digit selects
// with a blanking guard per slot, and feeds one shared BCD decoder.
module varredura_display
    import varredura_display_pkg::*;
#(
    parameter int N_DIG = N_DIG_PADRAO,
    parameter int DIV   = DIV_PADRAO,
    parameter int SLOT  = SLOT_PADRAO,
    parameter int BLANK = BLANK_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic [4*N_DIG-1:0] dados,
    input  logic               supr_zeros,
    output logic [3:0]         bcd,
    output logic               en_dec,
    output logic [N_DIG-1:0]   sel,
    output logic               quadro,
    output logic               pronto
);

    localparam int SW = $clog2(SLOT);
    localparam int IW = $clog2(N_DIG);

    estado_t            estado, estado_n;
    logic [SW-1:0]      slot, slot_n;
    logic [IW-1:0]      idx, idx_n;
    logic [4*N_DIG-1:0] exib, exib_n;
    logic [4*N_DIG-1:0] pend_val, pend_val_n;
    logic               pend, pend_n;
    logic               primo;
    logic               wrap;
    logic               tick;

    divisor_tick #(.DIV(DIV)) u_div (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    function automatic logic [3:0] digito(input logic [4*N_DIG-1:0] d,
                                          input logic [IW-1:0] k);
        return 4'(d >> {k, 2'b00});
    endfunction

    // A digit is dark if the decoder cannot show it, or if it is a
    // suppressed leading zero (digit 0 always shows).
    function automatic logic visivel(input logic [4*N_DIG-1:0] d,
                                     input logic [IW-1:0] k,
                                     input logic sz);
        logic zeros_acima;
        logic [3:0] v;
        zeros_acima = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (i >= int'(k) && d[4*i +: 4] != 4'd0) zeros_acima = 1'b0;
        end
        v = digito(d, k);
        return !((v > 4'd9) || (sz && (k != '0) && zeros_acima));
    endfunction

    always_comb begin
        estado_n   = estado;
        slot_n     = slot;
        idx_n      = idx;
        exib_n     = exib;
        pend_val_n = pend_val;
        pend_n     = pend;
        wrap       = 1'b0;
        if (tick) begin
            case (estado)
                APAGA: begin
                    slot_n = slot + 1'b1;
                    if (slot_n == SW'(BLANK)) estado_n = EXIBE;
                end
                EXIBE: begin
                    if (slot == SW'(SLOT - 1)) begin
                        slot_n   = '0;
                        estado_n = APAGA;
                        if (idx == IW'(N_DIG - 1)) begin
                            idx_n = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        slot_n = slot + 1'b1;
                    end
                end
                default: estado_n = APAGA;
            endcase
        end
        // Display only changes between frames; a same-cycle load stays pending.
        if (wrap && pend) begin
            exib_n = pend_val;
            pend_n = 1'b0;
        end
        if (carrega) begin
            pend_val_n = dados;
            pend_n     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= APAGA;
            slot     <= '0;
            idx      <= '0;
            exib     <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
            primo    <= 1'b1;
            sel      <= '0;
            bcd      <= '0;
            en_dec   <= 1'b0;
            quadro   <= 1'b0;
        end else begin
            estado   <= estado_n;
            slot     <= slot_n;
            idx      <= idx_n;
            exib     <= exib_n;
            pend_val <= pend_val_n;
            pend     <= pend_n;
            primo    <= 1'b0;
            quadro   <= wrap | primo;
            // Outputs follow the next state so they move one cycle after the tick.
            if (estado_n == EXIBE) begin
                sel    <= N_DIG'(1) << idx_n;
                bcd    <= digito(exib_n, idx_n);
                en_dec <= visivel(exib_n, idx_n, supr_zeros);
            end else begin
                sel    <= '0;
                bcd    <= '0;
                en_dec <= 1'b0;
            end
        end
    end

    assign pronto = ~pend;

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with a slot scoreboard: expected
// per-digit slots are queued with each load and checked as slots open.
module tb_varredura_display;

    logic        clock;
    logic        reset;
    logic        carrega;
    logic [15:0] dados;
    logic        supr_zeros;
    logic [3:0]  bcd;
    logic        en_dec;
    logic [3:0]  sel;
    logic        quadro;
    logic        pronto;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       en;
    } esp_t;

    esp_t fila[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_on   = 1'b0;
    logic [3:0] prev_sel = 4'b0;

    varredura_display #(
        .N_DIG (4),
        .DIV   (2),
        .SLOT  (4),
        .BLANK (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .carrega    (carrega),
        .dados      (dados),
        .supr_zeros (supr_zeros),
        .bcd        (bcd),
        .en_dec     (en_dec),
        .sel        (sel),
        .quadro     (quadro),
        .pronto     (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic vis(input logic [15:0] d, input int k, input logic s);
        logic [3:0] v;
        v = d[4*k +: 4];
        if (v > 4'd9) return 1'b0;
        if (s && k > 0 && (d >> (4*k)) == 16'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic s);
        esp_t e;
        for (int k = 0; k < 4; k++) begin
            e.sel = 4'(1 << k);
            e.bcd = d[4*k +: 4];
            e.en  = vis(d, k, s);
            fila.push_back(e);
        end
    endtask

    // Each new nonzero select marks the opening of a digit slot.
    always @(negedge clock) begin
        if (mon_on && sel !== 4'b0 && sel !== prev_sel) begin
            if (fila.size() == 0) begin
                chk("slot_inesperado", {12'b0, sel}, 16'h0);
            end else begin
                esp_t e;
                e = fila.pop_front();
                chk("sb_sel", {12'b0, sel}, {12'b0, e.sel});
                chk("sb_bcd", {12'b0, bcd}, {12'b0, e.bcd});
                chk("sb_en_dec", {15'b0, en_dec}, {15'b0, e.en});
            end
        end
        prev_sel <= sel;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [15:0] d);
        dados   = d;
        carrega = 1'b1;
        step();
        carrega = 1'b0;
    endtask

    task automatic wait_quadro();
        int n;
        n = 0;
        while (quadro !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("quadro_espera", {15'b0, quadro}, 16'h1);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        carrega    = 1'b0;
        dados      = 16'h0;
        supr_zeros = 1'b0;
        repeat (3) step();

        chk("rst_sel", {12'b0, sel}, 16'h0);
        chk("rst_en_dec", {15'b0, en_dec}, 16'h0);
        chk("rst_bcd", {12'b0, bcd}, 16'h0);
        chk("rst_quadro", {15'b0, quadro}, 16'h0);
        chk("rst_pronto", {15'b0, pronto}, 16'h1);

        push_frame(16'h0000, 1'b0);
        push_frame(16'h1234, 1'b0);
        mon_on = 1'b1;
        reset  = 1'b0;

        step();
        chk("quadro_pos_reset", {15'b0, quadro}, 16'h1);
        chk("sel_antes_tick", {12'b0, sel}, 16'h0);
        step();
        chk("sel_primeiro", {12'b0, sel}, 16'h1);
        chk("quadro_fim_pulso", {15'b0, quadro}, 16'h0);

        load(16'h1234);
        chk("pronto_carga", {15'b0, pronto}, 16'h0);
        wait_quadro();
        chk("pronto_volta", {15'b0, pronto}, 16'h1);
        chk("sel_inicio_quadro", {12'b0, sel}, 16'h0);

        repeat (3) step();
        load(16'h1111);
        repeat (5) step();
        load(16'h5678);
        push_frame(16'h5678, 1'b0);
        chk("pronto_duas_cargas", {15'b0, pronto}, 16'h0);
        wait_quadro();
        chk("pronto_5678", {15'b0, pronto}, 16'h1);

        load(16'h0050);
        push_frame(16'h0050, 1'b1);
        wait_quadro();
        supr_zeros = 1'b1;

        load(16'h0000);
        push_frame(16'h0000, 1'b1);
        wait_quadro();

        load(16'h00A3);
        push_frame(16'h00A3, 1'b0);
        wait_quadro();
        supr_zeros = 1'b0;

        n = 0;
        while (sel !== 4'b0100 && n < 200) begin
            step();
            n++;
        end
        chk("espera_digito2", {12'b0, sel}, 16'h4);
        load(16'h9999);
        chk("pronto_antes_reset", {15'b0, pronto}, 16'h0);
        chk("sel_ainda_digito2", {12'b0, sel}, 16'h4);

        mon_on = 1'b0;
        reset  = 1'b1;
        step();
        chk("mrst_sel", {12'b0, sel}, 16'h0);
        chk("mrst_en_dec", {15'b0, en_dec}, 16'h0);
        chk("mrst_pronto", {15'b0, pronto}, 16'h1);
        chk("mrst_bcd", {12'b0, bcd}, 16'h0);
        fila.delete();
        push_frame(16'h0000, 1'b0);
        push_frame(16'h0000, 1'b0);
        reset  = 1'b0;
        mon_on = 1'b1;

        n = 0;
        while (fila.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("fila_drenada", 16'(fila.size()), 16'h0);
        chk("pronto_final", {15'b0, pronto}, 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
